// File: rtl/bp_be_late_wb_buffer.sv
// Late writeback buffer: merges dcache-miss and long-latency unit results into one in-order FIFO.
// Latency: 1 cycle from enqueue to head output, no combinational bypass.
// Backpressure: readys come from registered occupancy only; force raised when nearly full or head too old.

`ifndef BP_BE_WB_PKT_WIDTH_DEFINED
`define BP_BE_WB_PKT_WIDTH_DEFINED
// ird_w_v, frd_w_v, fflags_w_v, rd_addr[4:0], rd_data[65:0], fflags[4:0]; the address width does
// not change the packet layout, the argument is kept so call sites match the original macro.
`define BP_BE_WB_PKT_WIDTH(vaddr_width_mp) (3 + 5 + 66 + 5 + 0 * (vaddr_width_mp))
`endif

package bp_be_late_wb_buffer_pkg;
  typedef enum logic [0:0] {
    e_bp_default_cfg = 1'b0,
    e_bp_wide_va_cfg = 1'b1
  } bp_params_e;
endpackage

module bp_be_late_wb_buffer
  import bp_be_late_wb_buffer_pkg::*;
#(
  parameter bp_params_e bp_params_p = e_bp_default_cfg,
  parameter int         els_p       = 4,
  parameter int         age_limit_p = 16,
  localparam int vaddr_width_p   = (bp_params_p == e_bp_default_cfg) ? 39 : 48,
  localparam int wb_pkt_width_lp = `BP_BE_WB_PKT_WIDTH(vaddr_width_p)
) (
  input  logic                       clk_i,
  input  logic                       reset_n_i,

  input  logic [wb_pkt_width_lp-1:0] mem_wb_pkt_i,
  input  logic                       mem_wb_v_i,
  output logic                       mem_wb_ready_and_o,

  input  logic [wb_pkt_width_lp-1:0] lat_wb_pkt_i,
  input  logic                       lat_wb_v_i,
  output logic                       lat_wb_ready_and_o,

  output logic [wb_pkt_width_lp-1:0] late_wb_pkt_o,
  output logic                       late_wb_v_o,
  output logic                       late_wb_force_o,
  input  logic                       late_wb_yumi_i
);

  localparam int ptr_w_lp = $clog2(els_p);
  localparam int cnt_w_lp = $clog2(els_p + 1);
  localparam int age_w_lp = $clog2(age_limit_p + 1);

  localparam logic [cnt_w_lp-1:0] els_lp        = cnt_w_lp'(els_p);
  localparam logic [cnt_w_lp-1:0] near_full_lp  = cnt_w_lp'(els_p - 1);
  localparam logic [cnt_w_lp-1:0] two_free_lp   = cnt_w_lp'(els_p - 2);
  localparam logic [age_w_lp-1:0] age_limit_lp  = age_w_lp'(age_limit_p);

  logic [wb_pkt_width_lp-1:0] mem_r [els_p];
  logic [ptr_w_lp-1:0]        rptr_r, wptr_r;
  logic [cnt_w_lp-1:0]        count_r;
  logic [age_w_lp-1:0]        age_r;

  logic       mem_enq, lat_enq, deq;
  logic [1:0] enq_cnt;

  // Port 1 needs two free slots so a same-cycle dual enqueue can never overflow.
  assign mem_wb_ready_and_o = (count_r < els_lp);
  assign lat_wb_ready_and_o = (count_r <= two_free_lp);

  assign mem_enq = mem_wb_v_i & mem_wb_ready_and_o;
  assign lat_enq = lat_wb_v_i & lat_wb_ready_and_o;
  assign deq     = late_wb_yumi_i & late_wb_v_o;
  assign enq_cnt = {1'b0, mem_enq} + {1'b0, lat_enq};

  assign late_wb_v_o     = (count_r != '0);
  assign late_wb_pkt_o   = mem_r[rptr_r];
  assign late_wb_force_o = late_wb_v_o & ((count_r >= near_full_lp) | (age_r >= age_limit_lp));

  // Storage write: port 0 takes the write pointer, port 1 lands behind it when both enqueue.
  always_ff @(posedge clk_i) begin
    if (mem_enq)
      mem_r[wptr_r] <= mem_wb_pkt_i;
    if (lat_enq)
      mem_r[wptr_r + ptr_w_lp'(mem_enq)] <= lat_wb_pkt_i;
  end

  // Pointer and occupancy bookkeeping; power-of-two depth makes pointer wrap free.
  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      rptr_r  <= '0;
      wptr_r  <= '0;
      count_r <= '0;
    end else begin
      wptr_r  <= wptr_r + ptr_w_lp'(enq_cnt);
      rptr_r  <= rptr_r + ptr_w_lp'(deq);
      count_r <= count_r + cnt_w_lp'(enq_cnt) - cnt_w_lp'(deq);
    end
  end

  // Head age: counts cycles the current head has waited, saturating at the limit.
  always_ff @(posedge clk_i) begin
    if (!reset_n_i || deq || !late_wb_v_o)
      age_r <= '0;
    else if (age_r < age_limit_lp)
      age_r <= age_r + 1'b1;
  end

`ifndef SYNTHESIS
  // Consuming an empty buffer is a scheduler bug; it is harmless here but worth reporting.
  always_ff @(posedge clk_i) begin
    if (reset_n_i)
      assert (!(late_wb_yumi_i && !late_wb_v_o))
      else $warning("late_wb_yumi_i asserted while buffer empty; ignored");
  end
`endif

endmodule

// File: tb/tb_bp_be_late_wb_buffer.sv
// Directed bench for the late writeback buffer with hand-computed expectations.
// Latency: checks run 1 time unit after each rising edge.
// Backpressure: ready/force outputs checked at fill, wrap, age and reset boundaries.
module tb_bp_be_late_wb_buffer;

  localparam int W = 79;

  logic         clk_i = 1'b0;
  logic         reset_n_i;
  logic [W-1:0] mem_wb_pkt_i, lat_wb_pkt_i, late_wb_pkt_o;
  logic         mem_wb_v_i, lat_wb_v_i, late_wb_yumi_i;
  logic         mem_wb_ready_and_o, lat_wb_ready_and_o, late_wb_v_o, late_wb_force_o;

  int pass_cnt  = 0;
  int check_cnt = 0;

  bp_be_late_wb_buffer dut (
    .clk_i              (clk_i),
    .reset_n_i          (reset_n_i),
    .mem_wb_pkt_i       (mem_wb_pkt_i),
    .mem_wb_v_i         (mem_wb_v_i),
    .mem_wb_ready_and_o (mem_wb_ready_and_o),
    .lat_wb_pkt_i       (lat_wb_pkt_i),
    .lat_wb_v_i         (lat_wb_v_i),
    .lat_wb_ready_and_o (lat_wb_ready_and_o),
    .late_wb_pkt_o      (late_wb_pkt_o),
    .late_wb_v_o        (late_wb_v_o),
    .late_wb_force_o    (late_wb_force_o),
    .late_wb_yumi_i     (late_wb_yumi_i)
  );

  always #5 clk_i = ~clk_i;

  // Distinct, bit-rich packet per id; id sits in the rd_addr-like top byte.
  function automatic logic [W-1:0] mk(input int id);
    logic [7:0]  a;
    logic [63:0] d;
    logic [6:0]  f;
    a = 8'(id);
    d = 64'hC0DE_0000_BEEF_0000 ^ {32'(id), 32'(id * 7)};
    f = 7'(id * 3);
    return {a, d, f};
  endfunction

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle_inputs();
    mem_wb_v_i     = 1'b0;
    lat_wb_v_i     = 1'b0;
    late_wb_yumi_i = 1'b0;
    mem_wb_pkt_i   = '0;
    lat_wb_pkt_i   = '0;
  endtask

  task automatic test_reset();
    idle_inputs();
    reset_n_i = 1'b0;
    step();
    step();
    check_cnt++;
    if ({late_wb_v_o, late_wb_force_o, mem_wb_ready_and_o, lat_wb_ready_and_o} !== 4'b0011)
      $display("FAIL reset_during v/force/mrdy/lrdy got %b want 0011",
               {late_wb_v_o, late_wb_force_o, mem_wb_ready_and_o, lat_wb_ready_and_o});
    else pass_cnt++;
    reset_n_i = 1'b1;
    step();
    check_cnt++;
    if ({late_wb_v_o, late_wb_force_o, mem_wb_ready_and_o, lat_wb_ready_and_o} !== 4'b0011)
      $display("FAIL reset_after v/force/mrdy/lrdy got %b want 0011",
               {late_wb_v_o, late_wb_force_o, mem_wb_ready_and_o, lat_wb_ready_and_o});
    else pass_cnt++;
  endtask

  task automatic test_single();
    mem_wb_v_i = 1'b1; mem_wb_pkt_i = mk(5);
    step();
    mem_wb_v_i = 1'b0;
    check_cnt++;
    if (late_wb_v_o !== 1'b1 || late_wb_pkt_o !== mk(5) || late_wb_force_o !== 1'b0)
      $display("FAIL single_head v=%b force=%b pkt=%h want v=1 force=0 pkt=%h",
               late_wb_v_o, late_wb_force_o, late_wb_pkt_o, mk(5));
    else pass_cnt++;
    late_wb_yumi_i = 1'b1;
    step();
    late_wb_yumi_i = 1'b0;
    check_cnt++;
    if (late_wb_v_o !== 1'b0)
      $display("FAIL single_drain v got %b want 0", late_wb_v_o);
    else pass_cnt++;
  endtask

  task automatic test_dual();
    mem_wb_v_i = 1'b1; mem_wb_pkt_i = mk(1);
    lat_wb_v_i = 1'b1; lat_wb_pkt_i = mk(2);
    step();
    mem_wb_v_i = 1'b0; lat_wb_v_i = 1'b0;
    late_wb_yumi_i = 1'b1;
    check_cnt++;
    if (late_wb_v_o !== 1'b1 || late_wb_pkt_o !== mk(1))
      $display("FAIL dual_first v=%b pkt=%h want v=1 pkt=%h", late_wb_v_o, late_wb_pkt_o, mk(1));
    else pass_cnt++;
    step();
    check_cnt++;
    if (late_wb_v_o !== 1'b1 || late_wb_pkt_o !== mk(2))
      $display("FAIL dual_second v=%b pkt=%h want v=1 pkt=%h", late_wb_v_o, late_wb_pkt_o, mk(2));
    else pass_cnt++;
    step();
    late_wb_yumi_i = 1'b0;
    check_cnt++;
    if (late_wb_v_o !== 1'b0)
      $display("FAIL dual_empty v got %b want 0", late_wb_v_o);
    else pass_cnt++;
  endtask

  task automatic test_fill_wrap();
    logic [W-1:0] exp_q[$];
    int next_id, got, budget;
    for (int i = 0; i < 3; i++) begin
      mem_wb_v_i = 1'b1; mem_wb_pkt_i = mk(10 + i);
      step();
    end
    mem_wb_v_i = 1'b0;
    check_cnt++;
    if ({lat_wb_ready_and_o, mem_wb_ready_and_o, late_wb_force_o} !== 3'b011)
      $display("FAIL fill3 lrdy/mrdy/force got %b want 011",
               {lat_wb_ready_and_o, mem_wb_ready_and_o, late_wb_force_o});
    else pass_cnt++;
    mem_wb_v_i = 1'b1; mem_wb_pkt_i = mk(13);
    step();
    mem_wb_v_i = 1'b0;
    check_cnt++;
    if (mem_wb_ready_and_o !== 1'b0 || late_wb_force_o !== 1'b1)
      $display("FAIL fill4 mrdy=%b force=%b want mrdy=0 force=1", mem_wb_ready_and_o, late_wb_force_o);
    else pass_cnt++;
    late_wb_yumi_i = 1'b1;
    step();
    late_wb_yumi_i = 1'b0;
    check_cnt++;
    if (mem_wb_ready_and_o !== 1'b1 || late_wb_pkt_o !== mk(11))
      $display("FAIL fill_pop mrdy=%b pkt=%h want mrdy=1 pkt=%h", mem_wb_ready_and_o, late_wb_pkt_o, mk(11));
    else pass_cnt++;
    exp_q.push_back(mk(11)); exp_q.push_back(mk(12)); exp_q.push_back(mk(13));
    // Stream 10 more packets across both ports while draining; order checked at every consume.
    next_id = 50; got = 0; budget = 0;
    while ((got < 13 || exp_q.size() != 0) && budget < 200) begin
      budget++;
      mem_wb_v_i = (next_id < 60);
      mem_wb_pkt_i = mk(next_id);
      lat_wb_v_i = (next_id + 1 < 60) && (budget % 2 == 0);
      lat_wb_pkt_i = mk(next_id + 1);
      late_wb_yumi_i = late_wb_v_o && (budget % 3 != 0);
      if (late_wb_yumi_i) begin
        check_cnt++;
        if (late_wb_pkt_o !== exp_q[0])
          $display("FAIL wrap_order item %0d pkt=%h want %h", got, late_wb_pkt_o, exp_q[0]);
        else pass_cnt++;
        void'(exp_q.pop_front());
        got++;
      end
      if (mem_wb_v_i && mem_wb_ready_and_o) begin
        exp_q.push_back(mk(next_id));
        next_id++;
        if (lat_wb_v_i && lat_wb_ready_and_o) begin
          exp_q.push_back(mk(next_id));
          next_id++;
        end
      end else if (lat_wb_v_i && lat_wb_ready_and_o) begin
        exp_q.push_back(mk(next_id + 1));
        lat_wb_pkt_i = mk(next_id + 1);
        next_id = next_id + 2;
      end
      step();
    end
    idle_inputs();
    check_cnt++;
    if (got !== 13 || late_wb_v_o !== 1'b0)
      $display("FAIL wrap_drained consumed=%0d v=%b want 13 and v=0", got, late_wb_v_o);
    else pass_cnt++;
  endtask

  task automatic test_aging();
    mem_wb_v_i = 1'b1; mem_wb_pkt_i = mk(20);
    step();
    mem_wb_v_i = 1'b0;
    for (int i = 0; i < 16; i++) begin
      check_cnt++;
      if (late_wb_force_o !== 1'b0)
        $display("FAIL age_young cycle %0d force got %b want 0", i + 1, late_wb_force_o);
      else pass_cnt++;
      step();
    end
    check_cnt++;
    if (late_wb_force_o !== 1'b1)
      $display("FAIL age_limit force got %b want 1", late_wb_force_o);
    else pass_cnt++;
    late_wb_yumi_i = 1'b1;
    step();
    late_wb_yumi_i = 1'b0;
    mem_wb_v_i = 1'b1; mem_wb_pkt_i = mk(21);
    step();
    mem_wb_v_i = 1'b0;
    check_cnt++;
    if (late_wb_v_o !== 1'b1 || late_wb_force_o !== 1'b0 || late_wb_pkt_o !== mk(21))
      $display("FAIL age_cleared v=%b force=%b pkt=%h want v=1 force=0 pkt=%h",
               late_wb_v_o, late_wb_force_o, late_wb_pkt_o, mk(21));
    else pass_cnt++;
    late_wb_yumi_i = 1'b1;
    step();
    late_wb_yumi_i = 1'b0;
  endtask

  task automatic test_back_to_back();
    mem_wb_v_i = 1'b1; mem_wb_pkt_i = mk(30);
    lat_wb_v_i = 1'b1; lat_wb_pkt_i = mk(31);
    step();
    mem_wb_pkt_i = mk(32);
    lat_wb_pkt_i = mk(33);
    late_wb_yumi_i = 1'b1;
    step();
    mem_wb_v_i = 1'b0; lat_wb_v_i = 1'b0;
    late_wb_yumi_i = 1'b0;
    check_cnt++;
    if ({lat_wb_ready_and_o, mem_wb_ready_and_o, late_wb_force_o} !== 3'b011 || late_wb_pkt_o !== mk(31))
      $display("FAIL simul_count3 lrdy/mrdy/force=%b pkt=%h want 011 pkt=%h",
               {lat_wb_ready_and_o, mem_wb_ready_and_o, late_wb_force_o}, late_wb_pkt_o, mk(31));
    else pass_cnt++;
    late_wb_yumi_i = 1'b1;
    for (int i = 31; i <= 33; i++) begin
      check_cnt++;
      if (late_wb_v_o !== 1'b1 || late_wb_pkt_o !== mk(i))
        $display("FAIL simul_order id %0d v=%b pkt=%h want %h", i, late_wb_v_o, late_wb_pkt_o, mk(i));
      else pass_cnt++;
      step();
    end
    late_wb_yumi_i = 1'b0;
    check_cnt++;
    if (late_wb_v_o !== 1'b0)
      $display("FAIL simul_empty v got %b want 0", late_wb_v_o);
    else pass_cnt++;
  endtask

  task automatic test_mid_reset();
    mem_wb_v_i = 1'b1; mem_wb_pkt_i = mk(40);
    lat_wb_v_i = 1'b1; lat_wb_pkt_i = mk(41);
    step();
    lat_wb_v_i = 1'b0;
    mem_wb_pkt_i = mk(42);
    step();
    mem_wb_v_i = 1'b0;
    check_cnt++;
    if (lat_wb_ready_and_o !== 1'b0 || late_wb_v_o !== 1'b1)
      $display("FAIL midrst_pre lrdy=%b v=%b want lrdy=0 v=1", lat_wb_ready_and_o, late_wb_v_o);
    else pass_cnt++;
    reset_n_i = 1'b0;
    step();
    reset_n_i = 1'b1;
    check_cnt++;
    if ({late_wb_v_o, late_wb_force_o, mem_wb_ready_and_o, lat_wb_ready_and_o} !== 4'b0011)
      $display("FAIL midrst_post v/force/mrdy/lrdy got %b want 0011",
               {late_wb_v_o, late_wb_force_o, mem_wb_ready_and_o, lat_wb_ready_and_o});
    else pass_cnt++;
    late_wb_yumi_i = 1'b1;
    step();
    late_wb_yumi_i = 1'b0;
    check_cnt++;
    if ({late_wb_v_o, late_wb_force_o, mem_wb_ready_and_o, lat_wb_ready_and_o} !== 4'b0011)
      $display("FAIL empty_yumi v/force/mrdy/lrdy got %b want 0011",
               {late_wb_v_o, late_wb_force_o, mem_wb_ready_and_o, lat_wb_ready_and_o});
    else pass_cnt++;
    mem_wb_v_i = 1'b1; mem_wb_pkt_i = mk(44);
    step();
    mem_wb_v_i = 1'b0;
    check_cnt++;
    if (late_wb_v_o !== 1'b1 || late_wb_pkt_o !== mk(44) || lat_wb_ready_and_o !== 1'b1)
      $display("FAIL midrst_reuse v=%b lrdy=%b pkt=%h want v=1 lrdy=1 pkt=%h",
               late_wb_v_o, lat_wb_ready_and_o, late_wb_pkt_o, mk(44));
    else pass_cnt++;
  endtask

  initial begin
    reset_n_i = 1'b0;
    idle_inputs();
    test_reset();
    test_single();
    test_dual();
    test_fill_wrap();
    test_aging();
    test_back_to_back();
    test_mid_reset();
    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule

// File: doc/bp_be_late_wb_buffer.md
BP_BE_LATE_WB_BUFFER -- requirements
Module: bp_be_late_wb_buffer

Interface
REQ-001 The block SHALL have the following parameters, one per line (name, default, meaning):
- bp_params_p, e_bp_default_cfg, processor configuration.
- els_p, 4, buffer depth in writeback packets; a power of two, at least 2.
- age_limit_p, 16, number of cycles the head entry may wait before force is raised.
REQ-002 The block SHALL have the following ports, one per line (name, direction, width, meaning):
- clk_i, in, 1, the single clock.
- reset_n_i, in, 1, reset; synchronous and active-low.
- mem_wb_pkt_i, in, wb_pkt_width_lp, late packet from the dcache miss return (port 0).
- mem_wb_v_i, in, 1, port 0 valid.
- mem_wb_ready_and_o, out, 1, port 0 ready.
- lat_wb_pkt_i, in, wb_pkt_width_lp, late packet from the long-latency int/fp units (port 1).
- lat_wb_v_i, in, 1, port 1 valid.
- lat_wb_ready_and_o, out, 1, port 1 ready.
- late_wb_pkt_o, out, wb_pkt_width_lp, head packet to the scheduler.
- late_wb_v_o, out, 1, head packet is valid.
- late_wb_force_o, out, 1, scheduler must take the head packet this cycle.
- late_wb_yumi_i, in, 1, scheduler consumes the head packet.
REQ-003 wb_pkt_width_lp SHALL equal `bp_be_wb_pkt_width(vaddr_width_p), and packets SHALL be stored and forwarded bit-exact.

Function
REQ-004 The storage SHALL be a circular FIFO with els_p entries, read pointer, write pointer, and occupancy count (0..els_p).
REQ-005 Both ready outputs SHALL depend on registered state only. They SHALL NOT depend on any valid or yumi input.
REQ-006 mem_wb_ready_and_o SHALL be 1 iff count < els_p.
REQ-007 lat_wb_ready_and_o SHALL be 1 iff count <= els_p-2, so a simultaneous two-port enqueue never overflows.
REQ-008 Enqueue on each port SHALL occur on v & ready.
- If only one port enqueues, its packet is written at the write pointer.
- If both ports enqueue in one cycle, the port 0 packet is written at the write pointer and the port 1 packet at write pointer+1 (mod els_p).
- The write pointer advances by the number of enqueues.
REQ-009 Dequeue SHALL occur on late_wb_yumi_i & late_wb_v_o, advancing the read pointer by 1 (mod els_p).
REQ-010 Next count SHALL equal count + enqueues - dequeue. Enqueue and dequeue in the same cycle are both legal, including at count = els_p-1 with both ports enqueuing.
REQ-011 Enqueue-to-output latency SHALL be 1 cycle: a packet enqueued into an empty buffer in cycle N appears on late_wb_pkt_o with late_wb_v_o=1 in cycle N+1. There is no combinational bypass.
REQ-012 late_wb_v_o SHALL be 1 iff count != 0.
- late_wb_pkt_o SHALL be the entry at the read pointer.
- When count = 0, late_wb_pkt_o value is don't-care.
REQ-013 late_wb_yumi_i asserted while late_wb_v_o=0 SHALL be ignored: no pointer or count change. A simulation assertion SHALL flag it.
REQ-014 The head-age counter SHALL increment, saturating at age_limit_p, each cycle late_wb_v_o=1 and no dequeue occurs. It SHALL clear to 0 on any dequeue or whenever count = 0.
REQ-015 late_wb_force_o SHALL be 1 iff late_wb_v_o=1 and either count >= els_p-1 or age >= age_limit_p. It depends on registered state only.
REQ-016 The block SHALL have no flush input: packets accepted are committed results and SHALL always be delivered, in enqueue order.
REQ-017 Pointer wrap SHALL be seamless: order is preserved across the els_p-1 -> 0 boundary.

Reset
REQ-018 When reset_n_i=0 at a rising clk_i, pointers, count and age counter SHALL clear to 0, including mid-operation with entries buffered. Buffered packets are discarded.
REQ-019 During and in the cycle after reset the outputs SHALL be: late_wb_v_o=0, late_wb_force_o=0, mem_wb_ready_and_o=1, lat_wb_ready_and_o=1. Storage contents need not be reset.

Verification
REQ-020 Single enqueue: port 0 packet A=rd_addr 5 in cycle 1, no yumi -> cycle 2 v_o=1, pkt_o=A, force_o=0; yumi in cycle 2 -> cycle 3 v_o=0.
REQ-021 Dual enqueue ordering: both ports valid in cycle 1 (P0=A, P1=B), yumi held high -> outputs A in cycle 2 and B in cycle 3, then v_o=0.
REQ-022 Fill and backpressure (els_p=4): enqueue 3 packets -> count 3, lat_ready=0, mem_ready=1, force_o=1. Enqueue a 4th -> mem_ready=0. One yumi -> mem_ready=1 the next cycle. Wrap order is checked over 10 packets.
REQ-023 Aging: 1 entry, no yumi -> force_o=0 for 16 cycles after it appears, force_o=1 from the 17th cycle. Yumi -> age clears and force_o=0.
REQ-024 Simultaneous events at count 2: P0+P1 enqueue plus yumi in the same cycle -> count 3 next cycle, FIFO order intact.
REQ-025 Mid-operation reset with count 3 -> next cycle v_o=0, both readys=1; yumi while empty -> no state change and the assertion fires.
